// File: rtl/arp_pkg.sv
// arp_pkg: shared widths, constants and types for the ARP resolver
package arp_pkg;
    localparam int MAC_W = 48;
    localparam int IP_W = 32;
    localparam int AGE_W = 16;
    localparam logic [MAC_W-1:0] BCAST_MAC = '1;
    localparam logic [MAC_W-1:0] ZERO_MAC = '0;
    typedef struct packed {
        logic valid;
        logic [IP_W-1:0] ip;
        logic [MAC_W-1:0] mac;
        logic [AGE_W-1:0] age;
    } arp_entry_t;
    typedef enum logic [1:0] {IDLE, CHECK, REQUEST, WAIT} resolver_state_t;
endpackage

// File: rtl/arp_resolver_if.sv
// arp_resolver_if: lookup/response and ARP request handshakes of the resolver
interface arp_resolver_if;
    import arp_pkg::*;
    logic lookup_valid;
    logic lookup_ready;
    logic [IP_W-1:0] lookup_ip;
    logic resp_valid;
    logic resp_hit;
    logic [MAC_W-1:0] resp_mac;
    logic req_valid;
    logic req_ready;
    logic [IP_W-1:0] req_tpa;
    logic [MAC_W-1:0] req_tha;
    modport master (
        output lookup_valid, lookup_ip, req_ready,
        input lookup_ready, resp_valid, resp_hit, resp_mac, req_valid, req_tpa, req_tha
    );
    modport slave (
        input lookup_valid, lookup_ip, req_ready,
        output lookup_ready, resp_valid, resp_hit, resp_mac, req_valid, req_tpa, req_tha
    );
endinterface

// File: rtl/arp_cache_table.sv
// arp_cache_table: IP-to-MAC cache with learn/replace, aging, flush and a match port
module arp_cache_table
    import arp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AGE_MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic learn_valid,
    input  logic [IP_W-1:0] learn_ip,
    input  logic [MAC_W-1:0] learn_mac,
    input  logic age_tick,
    input  logic flush,
    input  logic [IP_W-1:0] match_ip,
    output logic match_hit,
    output logic [MAC_W-1:0] match_mac,
    output logic [$clog2(DEPTH+1)-1:0] entries
);
    localparam int IW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH+1);
    arp_entry_t tbl_q [DEPTH];
    logic [IW-1:0] victim_q, wr_idx, learn_idx, free_idx;
    logic learn_found, free_found, learn_en;
    logic [NW-1:0] valid_cnt;
    // Descending scan so the lowest matching / free index wins
    always_comb begin
        learn_found = 1'b0;
        learn_idx = '0;
        free_found = 1'b0;
        free_idx = '0;
        match_hit = 1'b0;
        match_mac = ZERO_MAC;
        valid_cnt = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (tbl_q[i].valid && tbl_q[i].ip == learn_ip) begin
                learn_found = 1'b1;
                learn_idx = IW'(i);
            end
            if (!tbl_q[i].valid) begin
                free_found = 1'b1;
                free_idx = IW'(i);
            end
            if (tbl_q[i].valid && tbl_q[i].ip == match_ip) begin
                match_hit = 1'b1;
                match_mac = tbl_q[i].mac;
            end
            valid_cnt = valid_cnt + NW'(tbl_q[i].valid);
        end
        learn_en = learn_valid && learn_ip != '0;
        wr_idx = learn_found ? learn_idx : free_found ? free_idx : victim_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
            victim_q <= '0;
            entries <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush) tbl_q[i].valid <= 1'b0;
                else if (learn_en && wr_idx == IW'(i)) tbl_q[i] <= '{valid: 1'b1, ip: learn_ip, mac: learn_mac, age: '0};
                else if (age_tick && tbl_q[i].valid) begin
                    if (tbl_q[i].age >= AGE_W'(AGE_MAX)) tbl_q[i].valid <= 1'b0;
                    else tbl_q[i].age <= tbl_q[i].age + 1'b1;
                end
            end
            if (flush) victim_q <= '0;
            else if (learn_en && !learn_found && !free_found) victim_q <= victim_q + 1'b1;
            entries <= valid_cnt;
        end
    end
endmodule

// File: rtl/arp_resolver.sv
// arp_resolver: resolves IPs from the cache, issuing retried ARP requests on a miss
module arp_resolver
    import arp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TIMEOUT = 1024,
    parameter int RETRIES = 3,
    parameter int AGE_MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic learn_valid,
    input  logic [IP_W-1:0] learn_ip,
    input  logic [MAC_W-1:0] learn_mac,
    input  logic age_tick,
    input  logic flush,
    arp_resolver_if.slave bus,
    output logic [$clog2(DEPTH+1)-1:0] entries
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RW = (RETRIES > 1) ? $clog2(RETRIES) : 1;
    resolver_state_t state_q, state_d;
    logic [IP_W-1:0] ip_q;
    logic [CW-1:0] cnt_q;
    logic [RW-1:0] retry_q;
    logic resp_valid_q, resp_hit_q, resp_set, resp_hit_d, match_hit, reply, timeout;
    logic [MAC_W-1:0] resp_mac_q, resp_mac_d, match_mac;
    logic [$clog2(DEPTH+1)-1:0] ent;
    arp_cache_table #(.DEPTH(DEPTH), .AGE_MAX(AGE_MAX)) u_table (
        .clk(clk),
        .rst(rst),
        .learn_valid(learn_valid),
        .learn_ip(learn_ip),
        .learn_mac(learn_mac),
        .age_tick(age_tick),
        .flush(flush),
        .match_ip(ip_q),
        .match_hit(match_hit),
        .match_mac(match_mac),
        .entries(ent)
    );
    assign reply = learn_valid && learn_ip == ip_q;
    assign timeout = cnt_q == CW'(TIMEOUT - 1);
    always_comb begin
        state_d = state_q;
        resp_set = 1'b0;
        resp_hit_d = 1'b0;
        resp_mac_d = ZERO_MAC;
        case (state_q)
            IDLE: state_d = bus.lookup_valid ? CHECK : IDLE;
            CHECK: begin
                state_d = match_hit ? IDLE : REQUEST;
                resp_set = match_hit;
                resp_hit_d = match_hit;
                resp_mac_d = match_mac;
            end
            REQUEST: state_d = bus.req_ready ? WAIT : REQUEST;
            WAIT: begin
                // A reply arriving on the timeout cycle still resolves the lookup
                if (reply) begin
                    state_d = IDLE;
                    resp_set = 1'b1;
                    resp_hit_d = 1'b1;
                    resp_mac_d = learn_mac;
                end else if (timeout) begin
                    state_d = (retry_q < RW'(RETRIES - 1)) ? REQUEST : IDLE;
                    resp_set = retry_q >= RW'(RETRIES - 1);
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ip_q <= '0;
            cnt_q <= '0;
            retry_q <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q <= 1'b0;
            resp_mac_q <= ZERO_MAC;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.lookup_valid) ip_q <= bus.lookup_ip;
            cnt_q <= (state_q == WAIT) ? cnt_q + 1'b1 : '0;
            retry_q <= (state_q == CHECK) ? '0 : (state_q == WAIT && state_d == REQUEST) ? retry_q + 1'b1 : retry_q;
            resp_valid_q <= resp_set;
            resp_hit_q <= resp_hit_d;
            resp_mac_q <= resp_mac_d;
        end
    end
    // Outputs are forced low while rst is held so an abandoned request drops at once
    assign bus.lookup_ready = !rst && state_q == IDLE;
    assign bus.req_valid = !rst && state_q == REQUEST;
    assign bus.req_tpa = rst ? '0 : ip_q;
    assign bus.req_tha = ZERO_MAC;
    assign bus.resp_valid = !rst && resp_valid_q;
    assign bus.resp_hit = !rst && resp_hit_q;
    assign bus.resp_mac = rst ? ZERO_MAC : resp_mac_q;
    assign entries = rst ? '0 : ent;
endmodule
